// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Request/result bundle between a seq_alu and its requester.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y_lo;
    logic [WIDTH-1:0] y_hi;
    logic             zero;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, a, b,
        input  y_lo, y_hi, zero, busy, done, err
    );

    modport slave (
        input  start, op, a, b,
        output y_lo, y_hi, zero, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU: single-cycle logic/arith/compare ops, a
//               shift-add multiplier and an optional restoring divider
//               (enabled by defining SEQ_ALU_DIV_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam logic [2:0] c_op_and  = 3'd0;
    localparam logic [2:0] c_op_or   = 3'd1;
    localparam logic [2:0] c_op_add  = 3'd2;
    localparam logic [2:0] c_op_sub  = 3'd3;
    localparam logic [2:0] c_op_slt  = 3'd4;
    localparam logic [2:0] c_op_sltu = 3'd5;
    localparam logic [2:0] c_op_mulu = 3'd6;
    localparam logic [2:0] c_op_divu = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] y_lo_q, y_lo_d;
    logic [WIDTH-1:0] y_hi_q, y_hi_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH:0]   w_sum;
    logic             w_last;

    always_comb begin
        w_alu = '0;
        case (bus.op)
            c_op_and:  w_alu = bus.a & bus.b;
            c_op_or:   w_alu = bus.a | bus.b;
            c_op_add:  w_alu = bus.a + bus.b;
            c_op_sub:  w_alu = bus.a - bus.b;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default:   w_alu = '0;
        endcase
    end

    // Multiplier: hi holds the running partial product, lo the unconsumed
    // multiplier bits; both shift right one place per iteration.
    assign w_sum  = {1'b0, hi_q} + {1'b0, opnd_q};
    assign w_last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_ALU_DIV_EN
    // Divider: hi is the partial remainder, lo shifts the dividend out of its
    // top while quotient bits enter at the bottom.
    logic [WIDTH:0] w_trial;
    assign w_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        y_lo_d  = y_lo_q;
        y_hi_d  = y_hi_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == c_op_mulu) begin
                        hi_d    = '0;
                        lo_d    = bus.b;
                        opnd_d  = bus.a;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else if (bus.op == c_op_divu) begin
`ifdef SEQ_ALU_DIV_EN
                        if (bus.b == '0) begin
                            y_lo_d  = '1;
                            y_hi_d  = bus.a;
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            hi_d    = '0;
                            lo_d    = bus.a;
                            opnd_d  = bus.b;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
`else
                        y_lo_d  = '0;
                        y_hi_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        y_lo_d  = w_alu;
                        y_hi_d  = '0;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            MUL: begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {w_sum, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    y_lo_d  = lo_d;
                    y_hi_d  = hi_d;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end

`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                if (!w_trial[WIDTH]) begin
                    hi_d = w_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    y_lo_d  = lo_d;
                    y_hi_d  = hi_d;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
`endif

            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        zero_d = (y_lo_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            y_lo_q  <= '0;
            y_hi_q  <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            y_lo_q  <= y_lo_d;
            y_hi_q  <= y_hi_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign bus.y_lo = y_lo_q;
    assign bus.y_hi = y_hi_q;
    assign bus.zero = zero_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present a request once the DUT is idle; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Number of further edges until done is seen (0 means latency 1).
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.y_lo !== 32'h0) begin errors++; $display("FAIL reset_y_lo got %h exp 0", bus.y_lo); end
        checks++; if (bus.y_hi !== 32'h0) begin errors++; $display("FAIL reset_y_hi got %h exp 0", bus.y_hi); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sub();
        issue(3'd3, 32'h29, 32'h8);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sub_done got %b exp 1", bus.done); end
        checks++; if (bus.y_lo !== 32'h21) begin errors++; $display("FAIL sub_y_lo got %h exp 21", bus.y_lo); end
        checks++; if (bus.y_hi !== 32'h0) begin errors++; $display("FAIL sub_y_hi got %h exp 0", bus.y_hi); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL sub_zero got %b exp 0", bus.zero); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sub_err got %b exp 0", bus.err); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sub_pulse done=%b busy=%b exp 0 0", bus.done, bus.busy); end
        checks++; if (bus.y_lo !== 32'h21) begin errors++; $display("FAIL sub_hold got %h exp 21", bus.y_lo); end
        issue(3'd3, 32'h8, 32'h8);
        checks++; if (bus.y_lo !== 32'h0) begin errors++; $display("FAIL sub_eq_y_lo got %h exp 0", bus.y_lo); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL sub_eq_zero got %b exp 1", bus.zero); end
    endtask

    task automatic test_slt();
        issue(3'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        checks++; if (bus.y_lo !== 32'h0) begin errors++; $display("FAIL slt_neg got %h exp 0", bus.y_lo); end
        issue(3'd4, 32'hFFFF_FFFB, 32'hFFFF_FFFD);
        checks++; if (bus.y_lo !== 32'h1) begin errors++; $display("FAIL slt_swap got %h exp 1", bus.y_lo); end
        issue(3'd4, 32'h1, 32'hFFFF_FFFF);
        checks++; if (bus.y_lo !== 32'h0) begin errors++; $display("FAIL slt_mixed got %h exp 0", bus.y_lo); end
        issue(3'd5, 32'h1, 32'hFFFF_FFFF);
        checks++; if (bus.y_lo !== 32'h1) begin errors++; $display("FAIL sltu_mixed got %h exp 1", bus.y_lo); end
    endtask

    task automatic test_mulu();
        int n;
        logic busy_ok;
        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            // Stray request and operand churn mid-operation must be ignored.
            if (n == 10) begin bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'h5; bus.b = 32'h6; end
            if (n == 11) bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", n); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL mul_busy got %b exp 1", busy_ok); end
        checks++; if (bus.y_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_y_hi got %h exp fffffffe", bus.y_hi); end
        checks++; if (bus.y_lo !== 32'h1) begin errors++; $display("FAIL mul_y_lo got %h exp 1", bus.y_lo); end
        checks++; if (bus.err !== 1'b0 || bus.zero !== 1'b0) begin errors++; $display("FAIL mul_flags err=%b zero=%b exp 0 0", bus.err, bus.zero); end
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL mul_no_extra got %0d busy/done cycles exp 0", n); end

        issue(3'd6, 32'h8000_0000, 32'h4);
        wait_done(n);
        checks++; if (bus.y_hi !== 32'h2 || bus.y_lo !== 32'h0) begin errors++; $display("FAIL mul_shift got %h_%h exp 00000002_00000000", bus.y_hi, bus.y_lo); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL mul_zero got %b exp 1", bus.zero); end
    endtask

`ifdef SEQ_ALU_DIV_EN
    task automatic test_divu();
        int n;
        issue(3'd7, 32'd100, 32'd7);
        wait_done(n);
        checks++; if (n != 32) begin errors++; $display("FAIL div_latency got %0d exp 32", n); end
        checks++; if (bus.y_lo !== 32'd14) begin errors++; $display("FAIL div_quot got %0d exp 14", bus.y_lo); end
        checks++; if (bus.y_hi !== 32'd2) begin errors++; $display("FAIL div_rem got %0d exp 2", bus.y_hi); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL div_err got %b exp 0", bus.err); end
        issue(3'd7, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        checks++; if (bus.y_lo !== 32'h0FFF_FFFF || bus.y_hi !== 32'hF) begin errors++; $display("FAIL div_big got q=%h r=%h exp 0fffffff f", bus.y_lo, bus.y_hi); end
        issue(3'd7, 32'd5, 32'd0);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL div0_latency done=%b exp 1", bus.done); end
        checks++; if (bus.y_lo !== 32'hFFFF_FFFF || bus.y_hi !== 32'd5) begin errors++; $display("FAIL div0_result got %h %h exp ffffffff 00000005", bus.y_lo, bus.y_hi); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL div0_err got %b exp 1", bus.err); end
        issue(3'd2, 32'h1, 32'h1);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", bus.err); end
        issue(3'd7, 32'd9, 32'd0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL div0_again got %b exp 1", bus.err); end
    endtask
`else
    task automatic test_illegal();
        issue(3'd7, 32'd100, 32'd7);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ill_latency done=%b exp 1", bus.done); end
        checks++; if (bus.y_lo !== 32'h0 || bus.y_hi !== 32'h0) begin errors++; $display("FAIL ill_result got %h %h exp 0 0", bus.y_lo, bus.y_hi); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL ill_zero got %b exp 1", bus.zero); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", bus.err); end
        issue(3'd2, 32'h1, 32'h1);
        checks++; if (bus.err !== 1'b0 || bus.y_lo !== 32'h2) begin errors++; $display("FAIL err_clear err=%b y_lo=%h exp 0 2", bus.err, bus.y_lo); end
        issue(3'd7, 32'd3, 32'd3);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_again got %b exp 1", bus.err); end
    endtask
`endif

    task automatic test_reset_mid_mul();
        int n;
        issue(3'd6, 32'h3, 32'h5);
        repeat (9) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.y_lo !== 32'h0 || bus.y_hi !== 32'h0) begin errors++; $display("FAIL rst_mid_y got %h %h exp 0 0", bus.y_lo, bus.y_hi); end
        checks++; if (bus.zero !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags zero=%b err=%b exp 1 0", bus.zero, bus.err); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_busy busy=%b done=%b exp 0 0", bus.busy, bus.done); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL rst_abort got %0d busy/done cycles exp 0", n); end
        // Second reset: request presented together with release, accepted on the first edge.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'h1;
        bus.b     = 32'h2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.y_lo !== 32'h3) begin errors++; $display("FAIL rst_first_add done=%b y_lo=%h exp 1 3", bus.done, bus.y_lo); end
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++; if (bus.y_lo !== 32'hF000_F000) begin errors++; $display("FAIL and got %h exp f000f000", bus.y_lo); end
        issue(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++; if (bus.y_lo !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or got %h exp fff0fff0", bus.y_lo); end
        issue(3'd2, 32'hFFFF_FFFF, 32'h2);
        checks++; if (bus.y_lo !== 32'h1 || bus.y_hi !== 32'h0) begin errors++; $display("FAIL add_wrap got %h %h exp 1 0", bus.y_lo, bus.y_hi); end
        issue(3'd3, 32'h0, 32'h1);
        checks++; if (bus.y_lo !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin errors++; $display("FAIL sub_wrap got %h zero=%b exp ffffffff 0", bus.y_lo, bus.zero); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sub();
        test_slt();
        test_mulu();
`ifdef SEQ_ALU_DIV_EN
        test_divu();
`else
        test_illegal();
`endif
        test_reset_mid_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
